// File: rtl/csr_unit_pkg.sv
// Shared definitions for the M-mode CSR unit: CSR addresses, op encodings,
// mstatus bit positions and the read-modify-write helper.
package csr_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS_ADDR   = 12'h300;
    localparam logic [11:0] CSR_MISA_ADDR      = 12'h301;
    localparam logic [11:0] CSR_MIE_ADDR       = 12'h304;
    localparam logic [11:0] CSR_MTVEC_ADDR     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH_ADDR  = 12'h340;
    localparam logic [11:0] CSR_MEPC_ADDR      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE_ADDR    = 12'h342;
    localparam logic [11:0] CSR_MTVAL_ADDR     = 12'h343;
    localparam logic [11:0] CSR_MIP_ADDR       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE_ADDR    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET_ADDR  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH_ADDR   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH_ADDR = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID_ADDR = 12'hF11;
    localparam logic [11:0] CSR_MARCHID_ADDR   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID_ADDR    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID_ADDR   = 12'hF14;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    function automatic logic [31:0] csr_new_value(input logic [1:0] op,
                                                  input logic [31:0] old_val,
                                                  input logic [31:0] wdata);
        logic [31:0] result;
        result = old_val;
        case (op)
            CSR_OP_RW: result = wdata;
            CSR_OP_RS: result = old_val | wdata;
            CSR_OP_RC: result = old_val & ~wdata;
            default:   result = old_val;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter built from two 32-bit halves; a write to either half
// replaces the increment/carry for that half only.
module csr_counter64 (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [31:0] lo_q;
    logic [31:0] hi_q;
    logic        carry;

    // carry is taken from the pre-write low word
    assign carry = inc && (lo_q == 32'hFFFF_FFFF);
    assign value = {hi_q, lo_q};

    always_ff @(posedge clock) begin
        if (!reset) begin
            lo_q <= 32'd0;
            hi_q <= 32'd0;
        end else begin
            if (wr_lo)
                lo_q <= wdata;
            else if (inc)
                lo_q <= lo_q + 32'd1;

            if (wr_hi)
                hi_q <= wdata;
            else if (carry)
                hi_q <= hi_q + 32'd1;
        end
    end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: architected M-mode CSRs, CSRRW/RS/RC access,
// 64-bit cycle/instret counters, trap entry, mret and interrupt pending.
module csr_unit
    import csr_unit_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter bit          COUNTERS_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        instret,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_sw,
    output logic [31:0] trap_vector,
    output logic [31:0] mepc_out,
    output logic        irq_pending
);

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [63:0] mcycle_val;
    logic [63:0] minstret_val;

    logic [31:0] mstatus_val;
    logic [31:0] mip_val;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic [31:0] tvec_base;
    logic        implemented;
    logic        read_only;
    logic        op_active;
    logic        no_effect;
    logic        illegal;
    logic        do_write;

    always_comb begin
        mstatus_val               = 32'h0000_1800;
        mstatus_val[MSTATUS_MIE]  = mstatus_mie;
        mstatus_val[MSTATUS_MPIE] = mstatus_mpie;
    end

    assign mip_val = {20'd0, irq_ext, 3'd0, irq_timer, 3'd0, irq_sw, 3'd0};

    always_comb begin
        implemented = 1'b1;
        old_val     = 32'd0;
        case (csr_addr)
            CSR_MSTATUS_ADDR:   old_val = mstatus_val;
            CSR_MISA_ADDR:      old_val = MISA_VAL;
            CSR_MIE_ADDR:       old_val = mie_q;
            CSR_MTVEC_ADDR:     old_val = mtvec_q;
            CSR_MSCRATCH_ADDR:  old_val = mscratch_q;
            CSR_MEPC_ADDR:      old_val = mepc_q;
            CSR_MCAUSE_ADDR:    old_val = mcause_q;
            CSR_MTVAL_ADDR:     old_val = mtval_q;
            CSR_MIP_ADDR:       old_val = mip_val;
            CSR_MVENDORID_ADDR: old_val = 32'd0;
            CSR_MARCHID_ADDR:   old_val = 32'd0;
            CSR_MIMPID_ADDR:    old_val = 32'd0;
            CSR_MHARTID_ADDR:   old_val = HART_ID;
            CSR_MCYCLE_ADDR: begin
                implemented = COUNTERS_EN;
                old_val     = mcycle_val[31:0];
            end
            CSR_MCYCLEH_ADDR: begin
                implemented = COUNTERS_EN;
                old_val     = mcycle_val[63:32];
            end
            CSR_MINSTRET_ADDR: begin
                implemented = COUNTERS_EN;
                old_val     = minstret_val[31:0];
            end
            CSR_MINSTRETH_ADDR: begin
                implemented = COUNTERS_EN;
                old_val     = minstret_val[63:32];
            end
            default:            implemented = 1'b0;
        endcase
    end

    assign read_only = (csr_addr[11:10] == 2'b11);
    assign op_active = (csr_op != CSR_OP_NONE);
    assign no_effect = (csr_op != CSR_OP_RW) && (csr_wdata == 32'd0);
    assign illegal   = op_active &&
                       (!implemented ||
                        (read_only && ((csr_op == CSR_OP_RW) || (csr_wdata != 32'd0))));
    // trap and mret both take precedence over a software CSR write
    assign do_write  = op_active && !illegal && !no_effect && !trap_valid && !mret;
    assign new_val   = csr_new_value(csr_op, old_val, csr_wdata);

    assign csr_illegal = illegal;
    assign csr_rdata   = illegal ? 32'd0 : old_val;

    always_ff @(posedge clock) begin
        if (!reset) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_q        <= 32'd0;
            mtvec_q      <= MTVEC_RESET;
            mscratch_q   <= 32'd0;
            mepc_q       <= 32'd0;
            mcause_q     <= 32'd0;
            mtval_q      <= 32'd0;
        end else if (trap_valid) begin
            mepc_q       <= trap_pc & ~32'd3;
            mcause_q     <= trap_cause;
            mtval_q      <= trap_tval;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (do_write) begin
            case (csr_addr)
                CSR_MSTATUS_ADDR: begin
                    mstatus_mie  <= new_val[MSTATUS_MIE];
                    mstatus_mpie <= new_val[MSTATUS_MPIE];
                end
                CSR_MIE_ADDR:      mie_q      <= new_val & MIE_MASK;
                // reserved vector modes (1x) leave the current mode in place
                CSR_MTVEC_ADDR:    mtvec_q    <= {new_val[31:2],
                                                  new_val[1] ? mtvec_q[1:0] : new_val[1:0]};
                CSR_MSCRATCH_ADDR: mscratch_q <= new_val;
                CSR_MEPC_ADDR:     mepc_q     <= new_val & ~32'd3;
                CSR_MCAUSE_ADDR:   mcause_q   <= new_val;
                CSR_MTVAL_ADDR:    mtval_q    <= new_val;
                default: ;
            endcase
        end
    end

    csr_counter64 u_mcycle (
        .clock (clock),
        .reset (reset),
        .inc   (COUNTERS_EN),
        .wr_lo (do_write && (csr_addr == CSR_MCYCLE_ADDR)),
        .wr_hi (do_write && (csr_addr == CSR_MCYCLEH_ADDR)),
        .wdata (new_val),
        .value (mcycle_val)
    );

    csr_counter64 u_minstret (
        .clock (clock),
        .reset (reset),
        .inc   (COUNTERS_EN && instret),
        .wr_lo (do_write && (csr_addr == CSR_MINSTRET_ADDR)),
        .wr_hi (do_write && (csr_addr == CSR_MINSTRETH_ADDR)),
        .wdata (new_val),
        .value (minstret_val)
    );

    assign tvec_base   = {mtvec_q[31:2], 2'b00};
    assign trap_vector = ((mtvec_q[1:0] == 2'b01) && trap_cause[31])
                         ? tvec_base + {trap_cause[29:0], 2'b00}
                         : tvec_base;
    assign mepc_out    = mepc_q;
    assign irq_pending = mstatus_mie && |(mie_q & mip_val);

endmodule

// File: tb/tb_csr_unit.sv
// Directed-vector bench for csr_unit with hand-computed expected values.
module tb_csr_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instret;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret;
    logic        irq_ext;
    logic        irq_timer;
    logic        irq_sw;
    logic [31:0] trap_vector;
    logic [31:0] mepc_out;
    logic        irq_pending;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] rd_val;
    logic        rd_ill;

    csr_unit #(
        .HART_ID     (32'h0000_0003),
        .MISA_VAL    (32'h4000_0100),
        .MTVEC_RESET (32'h0000_0000),
        .COUNTERS_EN (1'b1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .csr_addr    (csr_addr),
        .csr_op      (csr_op),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .instret     (instret),
        .trap_valid  (trap_valid),
        .trap_cause  (trap_cause),
        .trap_pc     (trap_pc),
        .trap_tval   (trap_tval),
        .mret        (mret),
        .irq_ext     (irq_ext),
        .irq_timer   (irq_timer),
        .irq_sw      (irq_sw),
        .trap_vector (trap_vector),
        .mepc_out    (mepc_out),
        .irq_pending (irq_pending)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; the access spans one rising edge.
    task automatic do_op(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
        csr_addr  = a;
        csr_op    = op;
        csr_wdata = wd;
        #1;
        rd_val = csr_rdata;
        rd_ill = csr_illegal;
        @(negedge clock);
        csr_op    = 2'b00;
        csr_wdata = 32'd0;
    endtask

    task automatic rd(input logic [11:0] a);
        csr_addr = a;
        csr_op   = 2'b00;
        #1;
        rd_val = csr_rdata;
        rd_ill = csr_illegal;
    endtask

    initial begin
        reset = 1'b0; csr_addr = 12'd0; csr_op = 2'b00; csr_wdata = 32'd0;
        instret = 1'b0; trap_valid = 1'b0; trap_cause = 32'd0; trap_pc = 32'd0;
        trap_tval = 32'd0; mret = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0; irq_sw = 1'b0;

        repeat (3) @(negedge clock);
        rd(12'h300); check("reset_mstatus", rd_val, 32'h0000_1800);
        rd(12'h305); check("reset_mtvec", rd_val, 32'h0000_0000);
        rd(12'hB00); check("reset_mcycle", rd_val, 32'd0);

        reset = 1'b1;
        @(negedge clock);
        rd(12'hB00); check("mcycle_first", rd_val, 32'd1);
        @(negedge clock);
        rd(12'hB00); check("mcycle_second", rd_val, 32'd2);

        do_op(12'h340, 2'b01, 32'hDEAD_BEEF); check("rw_mscratch_old", rd_val, 32'd0);
        do_op(12'h340, 2'b10, 32'h0000_000F); check("rs_mscratch_old", rd_val, 32'hDEAD_BEEF);
        do_op(12'h340, 2'b11, 32'h0000_00F0); check("rc_mscratch_old", rd_val, 32'hDEAD_BEEF);
        rd(12'h340); check("mscratch_final", rd_val, 32'hDEAD_BE0F);

        do_op(12'hF14, 2'b01, 32'd5);
        check("rw_mhartid_illegal", {31'd0, rd_ill}, 32'd1);
        check("rw_mhartid_rdata", rd_val, 32'd0);
        do_op(12'hF14, 2'b10, 32'd0);
        check("rs0_mhartid_illegal", {31'd0, rd_ill}, 32'd0);
        check("rs0_mhartid_rdata", rd_val, 32'd3);
        do_op(12'h7C0, 2'b10, 32'd1);
        check("unimpl_illegal", {31'd0, rd_ill}, 32'd1);
        do_op(12'h301, 2'b01, 32'd0);
        rd(12'h301); check("misa_ro", rd_val, 32'h4000_0100);

        do_op(12'h304, 2'b01, 32'hFFFF_FFFF);
        rd(12'h304); check("mie_mask", rd_val, 32'h0000_0888);
        do_op(12'h304, 2'b01, 32'h0000_0080);
        do_op(12'h300, 2'b10, 32'h0000_0008);
        rd(12'h300); check("mstatus_mie_set", rd_val, 32'h0000_1808);
        check("irq_pending_idle", {31'd0, irq_pending}, 32'd0);
        irq_timer = 1'b1;
        rd(12'h344); check("mip_timer", rd_val, 32'h0000_0080);
        check("irq_pending_timer", {31'd0, irq_pending}, 32'd1);

        do_op(12'h305, 2'b01, 32'h0000_0101);
        do_op(12'h305, 2'b01, 32'h0000_0102);
        rd(12'h305); check("mtvec_bad_mode", rd_val, 32'h0000_0101);

        trap_valid = 1'b1; trap_cause = 32'h8000_0007; trap_pc = 32'h0000_1236; trap_tval = 32'h0000_00AB;
        #1; check("trap_vector_vec", trap_vector, 32'h0000_011C);
        trap_cause = 32'h0000_0002;
        #1; check("trap_vector_exc", trap_vector, 32'h0000_0100);
        trap_cause = 32'h8000_0007;
        @(negedge clock);
        trap_valid = 1'b0;
        rd(12'h300); check("trap_mstatus", rd_val, 32'h0000_1880);
        rd(12'h342); check("trap_mcause", rd_val, 32'h8000_0007);
        rd(12'h343); check("trap_mtval", rd_val, 32'h0000_00AB);
        check("trap_mepc_out", mepc_out, 32'h0000_1234);
        check("irq_pending_masked", {31'd0, irq_pending}, 32'd0);

        mret = 1'b1;
        @(negedge clock);
        mret = 1'b0;
        rd(12'h300); check("mret_mstatus", rd_val, 32'h0000_1888);
        irq_timer = 1'b0;

        do_op(12'hB02, 2'b01, 32'hFFFF_FFFF);
        instret = 1'b1;
        @(negedge clock);
        instret = 1'b0;
        rd(12'hB02); check("minstret_lo_wrap", rd_val, 32'd0);
        rd(12'hB82); check("minstret_hi_carry", rd_val, 32'd1);
        instret = 1'b1;
        do_op(12'hB02, 2'b01, 32'h0000_0010);
        instret = 1'b0;
        rd(12'hB02); check("minstret_write_wins", rd_val, 32'h0000_0010);
        rd(12'hB82); check("minstret_hi_kept", rd_val, 32'd1);
        do_op(12'hB00, 2'b01, 32'd7);
        rd(12'hB00); check("mcycle_write_wins", rd_val, 32'd7);

        do_op(12'h341, 2'b01, 32'h0000_5557);
        rd(12'h341); check("mepc_align", rd_val, 32'h0000_5554);

        trap_valid = 1'b1; trap_pc = 32'h0000_2002; trap_cause = 32'h0000_0002;
        do_op(12'h341, 2'b01, 32'h0000_5550);
        check("trap_wr_legal", {31'd0, rd_ill}, 32'd0);
        trap_valid = 1'b0;
        rd(12'h341); check("trap_beats_write", rd_val, 32'h0000_2000);

        reset = 1'b0; trap_valid = 1'b1;
        do_op(12'h340, 2'b01, 32'h0000_0005);
        reset = 1'b1; trap_valid = 1'b0;
        rd(12'h300); check("midreset_mstatus", rd_val, 32'h0000_1800);
        rd(12'h340); check("midreset_mscratch", rd_val, 32'd0);
        rd(12'h341); check("midreset_mepc", rd_val, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
